tmul_32_8x8: RTL and testbench

- Unsigned vector-by-matrix multiply ("tile multiply") of one 8-element vector of 32-bit words by an 8x8 matrix of 32-bit words.
- Produces 8 sums of 64-bit products, truncated to 64 bits.
- Datapath block inside the tile-math unit: combinational multiply/accumulate core followed by one output register stage.
- Multiplier implementation target is a Wallace-tree 32x32 multiplier.

---
 rtl/tmul_pkg.sv | 18 +
 rtl/mul32x32_wallace.sv | 42 ++++
 rtl/tmul_32_8x8.sv | 58 +++++
 tb/tb_tmul_32_8x8.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tmul_pkg.sv
// Shared constants, element types and the matrix-row element selector
// for the 8x8 tile vector-by-matrix multiply.
package tmul_pkg;

    localparam int N     = 8;
    localparam int W     = 32;
    localparam int ACC_W = 2 * W;

    typedef logic [W-1:0]     elem_t;
    typedef logic [N*W-1:0]   row_t;
    typedef logic [ACC_W-1:0] acc_t;

    // Element k of a row-packed matrix row: bits [k*W+W-1 : k*W].
    function automatic elem_t b_elem(input row_t row, input int unsigned k);
        return row[k*W +: W];
    endfunction

endpackage

// File: rtl/mul32x32_wallace.sv
// Combinational unsigned W x W -> 2W multiplier built as a Wallace tree:
// W shifted partial-product rows are reduced by 3:2 carry-save stages down
// to two rows, which a single carry-propagate adder then sums.
module mul32x32_wallace
    import tmul_pkg::*;
(
    input  elem_t x_i,
    input  elem_t y_i,
    output acc_t  p_o
);

    // Each 3:2 stage removes one row, so W rows need W-2 stages; the rows
    // are kept in one list that stages read in order and append to, which
    // makes consumption breadth-first and the tree depth logarithmic.
    localparam int NSTAGE = W - 2;
    localparam int NROW   = W + 2 * NSTAGE;

    // Partial-product generation, carry-save reduction and final add.
    always_comb begin
        acc_t rows [NROW];
        acc_t ra;
        acc_t rb;
        acc_t rc;
        for (int r = 0; r < NROW; r++) begin
            rows[r] = '0;
        end
        for (int j = 0; j < W; j++) begin
            rows[j] = x_i[j] ? (acc_t'(y_i) << j) : '0;
        end
        // The exact product fits in ACC_W bits, so carries shifted past
        // the top bit are always zero and truncation is lossless.
        for (int i = 0; i < NSTAGE; i++) begin
            ra = rows[3*i];
            rb = rows[3*i+1];
            rc = rows[3*i+2];
            rows[W+2*i]   = ra ^ rb ^ rc;
            rows[W+2*i+1] = ((ra & rb) | (ra & rc) | (rb & rc)) << 1;
        end
        p_o = rows[NROW-2] + rows[NROW-1];
    end

endmodule

// File: rtl/tmul_32_8x8.sv
// Tile multiply: c[k] = sum_j A[j]*B[j][k] mod 2^64 for an 8-element
// vector and 8x8 matrix of unsigned 32-bit words. 64 parallel multipliers
// feed eight 3-level adder trees; one output register gives 1-cycle
// latency at full throughput with no handshake.
module tmul_32_8x8
    import tmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a [N-1:0],
    input  logic [N*W-1:0]   b [N-1:0],
    output logic [ACC_W-1:0] c [N-1:0]
);

    acc_t prod [N][N];   // prod[j][k] = A[j] * B[j][k]
    acc_t c_d  [N];
    acc_t c_q  [N];

    for (genvar j = 0; j < N; j++) begin : g_row
        for (genvar k = 0; k < N; k++) begin : g_col
            mul32x32_wallace u_mul (
                .x_i (a[j]),
                .y_i (b_elem(b[j], k)),
                .p_o (prod[j][k])
            );
        end
    end

    // Per-column balanced adder tree; carries above bit 63 are dropped.
    always_comb begin
        acc_t l1 [4];
        acc_t l2 [2];
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < 4; m++) begin
                l1[m] = prod[2*m][k] + prod[2*m+1][k];
            end
            l2[0]  = l1[0] + l1[1];
            l2[1]  = l1[2] + l1[3];
            c_d[k] = l2[0] + l2[1];
        end
    end

    // Output register: loads every cycle, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                c_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                c_q[k] <= c_d[k];
            end
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_tmul_32_8x8.sv
// Directed bench for tmul_32_8x8: a table of single-cycle vectors with
// hand-derived results, plus sequences for reset and back-to-back input.
module tb_tmul_32_8x8;

    typedef struct packed {
        logic [7:0][31:0]  va;
        logic [7:0][255:0] vb;
        logic [7:0][63:0]  vc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] a [8];
    logic [255:0] b [8];
    logic [63:0] c [8];

    int checks;
    int errors;

    vec_t tbl [7];
    string tbl_name [7];

    tmul_32_8x8 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        for (int j = 0; j < 8; j++) begin
            a[j] = v.va[j];
            b[j] = v.vb[j];
        end
    endtask

    task automatic check_c(input string name, input logic [7:0][63:0] exp);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (c[k] !== exp[k]) begin
                errors++;
                $display("FAIL %s c[%0d]: got %h expected %h", name, k, c[k], exp[k]);
            end
        end
    endtask

    function automatic vec_t ramp(input int i);
        vec_t v;
        for (int j = 0; j < 8; j++) begin
            v.va[j] = 32'(j + 1 + i);
            for (int k = 0; k < 8; k++) v.vb[j][k*32 +: 32] = 32'(k + 1 + i);
        end
        // sum_j (j+1+i) = 36 + 8i
        for (int k = 0; k < 8; k++) v.vc[k] = 64'((36 + 8*i) * (k + 1 + i));
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [7:0][63:0] zero_c;
        checks = 0;
        errors = 0;
        zero_c = '0;

        // ---- build vector table ----
        tbl[0] = ramp(0); tbl_name[0] = "ramp0";
        // identity
        v = '0;
        for (int j = 0; j < 8; j++) begin
            v.va[j] = 32'(j + 1);
            v.vb[j][j*32 +: 32] = 32'd1;
            v.vc[j] = 64'(j + 1);
        end
        tbl[1] = v; tbl_name[1] = "identity";
        // permutation B[j][7-j]=1 -> reversed
        v = '0;
        for (int j = 0; j < 8; j++) begin
            v.va[j] = 32'(j + 1);
            v.vb[j][(7-j)*32 +: 32] = 32'd1;
            v.vc[7-j] = 64'(j + 1);
        end
        tbl[2] = v; tbl_name[2] = "permute";
        // all ones: 8*(2^32-1)^2 mod 2^64
        v = '1;
        for (int k = 0; k < 8; k++) v.vc[k] = 64'hFFFFFFF000000008;
        tbl[3] = v; tbl_name[3] = "all_ff";
        // single max product
        v = '0;
        v.va[0] = 32'hFFFFFFFF;
        v.vb[0][31:0] = 32'hFFFFFFFF;
        v.vc[0] = 64'hFFFFFFFE00000001;
        tbl[4] = v; tbl_name[4] = "single";
        // zero a, random B
        v = '0;
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 8; k++) v.vb[j][k*32 +: 32] = $urandom;
        tbl[5] = v; tbl_name[5] = "zero_a";
        // one-hot a[3]=5
        v.va[3] = 32'd5;
        for (int k = 0; k < 8; k++) v.vc[k] = 64'd5 * {32'd0, v.vb[3][k*32 +: 32]};
        tbl[6] = v; tbl_name[6] = "onehot";

        // ---- reset held with nonzero inputs ----
        rst = 1'b1;
        drive(tbl[3]);
        repeat (3) @(posedge clk);
        #1 check_c("reset_hold", zero_c);
        @(negedge clk) rst = 1'b0;

        // ---- table-driven vectors ----
        for (int t = 0; t < 7; t++) begin
            @(negedge clk) drive(tbl[t]);
            @(posedge clk);
            #1 check_c(tbl_name[t], tbl[t].vc);
        end

        // ---- back-to-back ramp, new input every cycle ----
        @(negedge clk) drive(ramp(0));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            v = ramp(i);
            check_c($sformatf("ramp_seq%0d", i), v.vc);
            if (i < 9) drive(ramp(i + 1));
        end

        // ---- asynchronous reset between edges ----
        @(negedge clk) drive(tbl[3]);
        @(posedge clk);
        #1 check_c("pre_async", tbl[3].vc);
        #2 rst = 1'b1;
        #1 check_c("async_rst", zero_c);
        // in-flight inputs change while in reset; first edge after release loads them
        drive(ramp(1));
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        v = ramp(1);
        #1 check_c("post_rst", v.vc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
